dmem_lsu_bridge: RTL and testbench

- Memory-side stage directly downstream of store byte-lane steering and upstream of writeback.
- Accepts one load/store per request from the MEM stage and drives a single-outstanding data-memory bus with req/gnt/rvalid handshake.
- Stalls the pipeline until the access completes.
- For loads, extracts the addressed byte/half from the returned word and sign/zero-extends it.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_lsu_bridge_load_extend.sv | 44 ++++
 rtl/dmem_lsu_bridge.sv | 182 ++++++++++++++++++
 tb/tb_dmem_lsu_bridge.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory load/store bridge:
//   - load/store funct3 encodings
//   - bridge FSM state enum
//   - full-word byte-enable constant
//   - misalignment predicate, used when DMEM_MISALIGN_TRAP_EN is defined
// ---------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } dmem_state_e;

   // Halfword accesses (LH/LHU/SH) need addr[0] = 0.
   // Word accesses (LW/SW) need addr[1:0] = 0.
   // Stores share the LH/LW encodings for SH/SW.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] off);
      logic r;
      case (funct3)
         F3_LH, F3_LHU: r = off[0];
         F3_LW:         r = (off != 2'b00);
         default:       r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_lsu_bridge_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational load-data extraction. Selects the addressed byte or
// halfword from a 32-bit memory word, then sign- or zero-extends it
// according to the load type. Reserved load types return zero.
// Kept free of state so a future cache return path can reuse it.
//
// Ports:
//   rdata_i  [31:0] raw word returned by memory
//   off_i    [1:0]  byte offset of the access inside the word
//   funct3_i [2:0]  load type (LB/LH/LW/LBU/LHU)
//   data_o   [31:0] extended load result
// ---------------------------------------------------------------------------
module load_extend
   import dmem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection, then extension by load type.
   always_comb begin
      byte_s = rdata_i[{off_i, 3'b000} +: 8];
      if (off_i[1]) begin
         half_s = rdata_i[31:16];
      end else begin
         half_s = rdata_i[15:0];
      end
      case (funct3_i)
         F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
         F3_LBU:  data_o = {24'h00_0000, byte_s};
         F3_LH:   data_o = {{16{half_s[15]}}, half_s};
         F3_LHU:  data_o = {16'h0000, half_s};
         F3_LW:   data_o = rdata_i;
         default: data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/dmem_lsu_bridge.sv
// ---------------------------------------------------------------------------
// dmem_lsu_bridge
// MEM-stage to data-memory bridge. Accepts one load/store at a time,
// drives a single-outstanding req/gnt/rvalid bus, and stalls the
// pipeline until the access completes. Load data is extracted and
// extended by load_extend before it is registered onto ld_data.
//
// Optional feature: define DMEM_MISALIGN_TRAP_EN to add the 'misalign'
// output. Misaligned half/word accesses then skip the bus and report
// misalign for one cycle. Without it, addresses are word-truncated.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   req_valid/we/addr   MEM-stage access request
//   req_wdata/be        lane-steered store data and byte enables
//   req_funct3          load type
//   stall               hold pipeline (combinational)
//   ld_valid, ld_data   one-cycle load result
//   mem_req/we/addr     bus request, word-aligned address
//   mem_wdata/be        bus write data and byte enables
//   mem_gnt             bus accepted the request
//   mem_rvalid/rdata    bus read response
//   misalign            (DMEM_MISALIGN_TRAP_EN only) misaligned access
// ---------------------------------------------------------------------------
module dmem_lsu_bridge
   import dmem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic [3:0]    req_be,
   input  logic [2:0]    req_funct3,
   output logic          stall,
   output logic          ld_valid,
   output logic [DW-1:0] ld_data,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_be,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata
`ifdef DMEM_MISALIGN_TRAP_EN
   ,
   output logic          misalign
`endif
);

   dmem_state_e   state_q;
   logic          mem_req_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [3:0]    mem_be_q;
   logic          ld_valid_q;
   logic [DW-1:0] ld_data_q;
   logic [1:0]    off_q;
   logic [2:0]    funct3_q;
   logic [31:0]   ext_s;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic          misalign_q;
   logic          misalign_d;

   // Misalignment is judged on the live request, since it decides the IDLE exit.
   always_comb begin
      if (req_valid) begin
         misalign_d = is_misaligned(req_funct3, req_addr[1:0]);
      end else begin
         misalign_d = 1'b0;
      end
   end

   assign misalign = misalign_q;
`endif

   // The extractor works from the captured offset and type only,
   // so request changes after IDLE cannot disturb the result.
   load_extend u_load_extend (
      .rdata_i  (mem_rdata),
      .off_i    (off_q),
      .funct3_i (funct3_q),
      .data_o   (ext_s)
   );

   // The pipeline advances exactly in the RESP cycle.
   assign stall = req_valid & (state_q != ST_RESP);

   // Bridge FSM with all bus and load outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= 4'b0000;
         ld_valid_q  <= 1'b0;
         ld_data_q   <= '0;
         off_q       <= 2'b00;
         funct3_q    <= 3'b000;
`ifdef DMEM_MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  mem_we_q    <= req_we;
                  mem_addr_q  <= {req_addr[AW-1:2], 2'b00};
                  mem_wdata_q <= req_wdata;
                  // Loads always fetch the whole word and extract afterwards.
                  mem_be_q    <= req_we ? req_be : BE_WORD;
                  off_q       <= req_addr[1:0];
                  funct3_q    <= req_funct3;
`ifdef DMEM_MISALIGN_TRAP_EN
                  if (misalign_d) begin
                     mem_req_q  <= 1'b0;
                     misalign_q <= 1'b1;
                     state_q    <= ST_RESP;
                  end else begin
                     mem_req_q  <= 1'b1;
                     state_q    <= ST_REQ;
                  end
`else
                  mem_req_q   <= 1'b1;
                  state_q     <= ST_REQ;
`endif
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_REQ: begin
               // rvalid is not sampled here: the bus cannot respond in the grant cycle.
               if (mem_gnt) begin
                  mem_req_q <= 1'b0;
                  state_q   <= mem_we_q ? ST_RESP : ST_WAIT;
               end else begin
                  state_q <= ST_REQ;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  ld_data_q  <= ext_s;
                  ld_valid_q <= 1'b1;
                  state_q    <= ST_RESP;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_RESP: begin
               ld_valid_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
               misalign_q <= 1'b0;
`endif
               state_q    <= ST_IDLE;
            end
            default: begin
               mem_req_q  <= 1'b0;
               ld_valid_q <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign ld_valid  = ld_valid_q;
   assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_lsu_bridge
// Scoreboard bench for dmem_lsu_bridge. Stimulus pushes expected bus
// transactions and load results into queues. A monitor pops and compares
// them whenever the DUT presents mem_req or ld_valid. A bus responder
// process supplies gnt/rvalid with a configurable grant delay.
// The misalign port and trap expectations follow DMEM_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_dmem_lsu_bridge;
   import dmem_pkg::*;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic [2:0]  req_funct3;
   logic        stall, ld_valid;
   logic [31:0] ld_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int total = 0;
   int bad   = 0;

   bus_t        exp_bus[$];
   logic [31:0] exp_ld[$];

   // Responder knobs
   int          gdelay   = 0;
   int          rv_delay = 0;
   bit          spur     = 1'b0;
   logic [31:0] resp_data = 32'h0;

   always #5 clk = ~clk;

   dmem_lsu_bridge #(.AW(32), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .req_funct3 (req_funct3),
      .stall      (stall),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
`ifdef DMEM_MISALIGN_TRAP_EN
      ,
      .misalign   (misalign)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus responder: acts 2 time units after each rising edge.
   initial begin
      int  gcnt;
      int  rv_cnt;
      bit  rv_pend;
      gcnt = 0; rv_cnt = 0; rv_pend = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         mem_rvalid = 1'b0;
         if (mem_gnt) begin
            mem_gnt = 1'b0;
            if (!mem_we) begin
               rv_pend = 1'b1;
               rv_cnt  = rv_delay;
            end
         end else if (rv_pend) begin
            rv_cnt--;
         end
         if (rv_pend && rv_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = resp_data;
            rv_pend    = 1'b0;
         end
         if (!mem_req) begin
            gcnt = 0;
         end else if (!mem_gnt) begin
            if (spur) begin
               mem_rvalid = 1'b1;
               mem_rdata  = 32'hBAD0_BAD0;
            end
            if (gcnt >= gdelay) begin
               mem_gnt = 1'b1;
               gcnt    = 0;
            end else begin
               gcnt++;
            end
         end
      end
   end

   // Monitor: compares bus requests every cycle they are presented, and load results.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mem_req) begin
               if (exp_bus.size() == 0) begin
                  chk("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
               end else begin
                  chk("mem_we",    {31'd0, mem_we},  {31'd0, exp_bus[0].we});
                  chk("mem_addr",  mem_addr,         exp_bus[0].addr);
                  chk("mem_wdata", mem_wdata,        exp_bus[0].wdata);
                  chk("mem_be",    {28'd0, mem_be},  {28'd0, exp_bus[0].be});
                  if (mem_gnt) void'(exp_bus.pop_front());
               end
            end
            if (ld_valid) begin
               if (exp_ld.size() == 0) begin
                  chk("unexpected_ld_valid", {31'd0, ld_valid}, 32'd0);
               end else begin
                  chk("ld_data", ld_data, exp_ld.pop_front());
               end
            end
         end
      end
   end

   // One access: push expectations, drive the request, count stall cycles.
   task automatic access(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [2:0] f3,
                         input int gd, input bit sp, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data, input bit mis);
      bus_t b;
      int   scnt;
      int   exp_stall;
      gdelay    = gd;
      spur      = sp;
      resp_data = rdata;
      if (!mis) begin
         b.we = we; b.addr = exp_addr; b.wdata = wdata; b.be = we ? be : 4'b1111;
         exp_bus.push_back(b);
         if (!we) exp_ld.push_back(exp_data);
      end
      exp_stall = mis ? 1 : ((we ? 2 : 3) + gd);
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_we = we; req_addr = addr;
      req_wdata = wdata; req_be = be; req_funct3 = f3;
      scnt = 0;
      while (1) begin
         @(negedge clk);
         if (!stall) break;
         scnt++;
         // Scramble the request once the access has been captured.
         if (scnt == 2) begin
            req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
            req_be = ~be; req_funct3 = f3 ^ 3'b111;
         end
         if (scnt > 60) begin
            chk({tag, "_stall_timeout"}, {31'd0, stall}, 32'd0);
            break;
         end
      end
      chk({tag, "_stall_cycles"}, scnt, exp_stall);
      chk({tag, "_ld_valid_in_resp"}, {31'd0, ld_valid}, {31'd0, (!we && !mis)});
`ifdef DMEM_MISALIGN_TRAP_EN
      chk({tag, "_misalign"}, {31'd0, misalign}, {31'd0, mis});
`endif
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
      req_wdata = 32'h0; req_be = 4'h0; req_funct3 = 3'b000;

      // Reset state
      @(negedge clk);
      chk("rst_mem_req",   {31'd0, mem_req},  32'd0);
      chk("rst_mem_we",    {31'd0, mem_we},   32'd0);
      chk("rst_ld_valid",  {31'd0, ld_valid}, 32'd0);
      chk("rst_mem_addr",  mem_addr,          32'd0);
      chk("rst_mem_wdata", mem_wdata,         32'd0);
      chk("rst_mem_be",    {28'd0, mem_be},   32'd0);
      chk("rst_ld_data",   ld_data,           32'd0);
      chk("rst_stall",     {31'd0, stall},    32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("rst_misalign",  {31'd0, misalign}, 32'd0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;

      //     tag      we    addr          wdata         be      f3      gd sp rdata         exp_addr      exp_data      mis
      access("sw",    1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 3'b010, 0, 0, 32'h0,        32'h0000_0100, 32'h0,        1'b0);
      access("lb",    1'b0, 32'h0000_0203, 32'h0,         4'b0001, F3_LB,  0, 0, 32'h8011_2233, 32'h0000_0200, 32'hFFFF_FF80, 1'b0);
      access("lhu",   1'b0, 32'h0000_0302, 32'h0,         4'b0000, F3_LHU, 0, 0, 32'hBEEF_1234, 32'h0000_0300, 32'h0000_BEEF, 1'b0);
      access("lh",    1'b0, 32'h0000_0302, 32'h0,         4'b0000, F3_LH,  0, 0, 32'hBEEF_1234, 32'h0000_0300, 32'hFFFF_BEEF, 1'b0);
      access("lw_gd5",1'b0, 32'h0000_0400, 32'h5555_AAAA, 4'b0000, F3_LW,  5, 1, 32'hCAFE_F00D, 32'h0000_0400, 32'hCAFE_F00D, 1'b0);
      access("sb_gd2",1'b1, 32'h0000_0505, 32'h0000_AB00, 4'b0010, 3'b000, 2, 0, 32'h0,        32'h0000_0504, 32'h0,        1'b0);
      access("lbu",   1'b0, 32'h0000_0601, 32'h0,         4'b0000, F3_LBU, 0, 0, 32'h1234_F678, 32'h0000_0600, 32'h0000_00F6, 1'b0);
      access("lb_pos",1'b0, 32'h0000_0600, 32'h0,         4'b0000, F3_LB,  0, 0, 32'h8000_007F, 32'h0000_0600, 32'h0000_007F, 1'b0);
      access("lhu_lo",1'b0, 32'h0000_0700, 32'h0,         4'b0000, F3_LHU, 1, 0, 32'h0001_8000, 32'h0000_0700, 32'h0000_8000, 1'b0);
      access("lh_lo", 1'b0, 32'h0000_0700, 32'h0,         4'b0000, F3_LH,  0, 0, 32'h0001_8000, 32'h0000_0700, 32'hFFFF_8000, 1'b0);
      access("rsv011",1'b0, 32'h0000_0800, 32'h0,         4'b0000, 3'b011, 0, 0, 32'hFFFF_FFFF, 32'h0000_0800, 32'h0,        1'b0);
      access("rsv110",1'b0, 32'h0000_0804, 32'h0,         4'b0000, 3'b110, 0, 0, 32'hFFFF_FFFF, 32'h0000_0804, 32'h0,        1'b0);
      access("lw_mis",1'b0, 32'h0000_0102, 32'h0,         4'b0000, F3_LW,  0, 0, 32'h1122_3344, 32'h0000_0100, 32'h1122_3344, TRAP);
      access("lh_mis",1'b0, 32'h0000_0101, 32'h0,         4'b0000, F3_LH,  0, 0, 32'hA5B6_C7D8, 32'h0000_0100, 32'hFFFF_C7D8, TRAP);
      access("sw_mis",1'b1, 32'h0000_0106, 32'h0102_0304, 4'b1111, 3'b010, 0, 0, 32'h0,        32'h0000_0104, 32'h0,        TRAP);

      // Reset while waiting for load data; the late rvalid must be ignored.
      gdelay = 0; spur = 1'b0; rv_delay = 2; resp_data = 32'h8000_0080;
      exp_bus.push_back('{1'b0, 32'h0000_0900, 32'h0, 4'b1111});
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0903;
      req_wdata = 32'h0; req_be = 4'h0; req_funct3 = F3_LB;
      @(posedge clk);
      @(posedge clk);
      #3;
      chk("wait_stall", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      req_valid = 1'b0;
      #1;
      chk("midrst_mem_req",  {31'd0, mem_req}, 32'd0);
      chk("midrst_mem_addr", mem_addr,         32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("postrst_mem_req",  {31'd0, mem_req},  32'd0);
         chk("postrst_ld_valid", {31'd0, ld_valid}, 32'd0);
         chk("postrst_ld_data",  ld_data,           32'd0);
      end
      rv_delay = 0;

      // Recovery after reset
      access("lbu_rec",1'b0, 32'h0000_0A02, 32'h0,        4'b0000, F3_LBU, 0, 0, 32'h00C3_0000, 32'h0000_0A00, 32'h0000_00C3, 1'b0);

      repeat (4) @(negedge clk);
      chk("bus_queue_empty", exp_bus.size(), 32'd0);
      chk("ld_queue_empty",  exp_ld.size(),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
